vtg_mux_arbiter: RTL and testbench
==================================

// Module: vtg_mux_arbiter
// PURPOSE
//   Arbitrates shared use of the vtg_mux 2:1 datapath between requester X and requester Y.
//   - Decides each cycle which requester owns the mux.
//   - Drives the registered mux select line (sel: 0 = X, 1 = Y).
//   - Issues one-hot grants; a grant is never asserted in the same cycle sel changes (break-before-make).
//   - Round-robin fairness, plus a bounded hold time when the other side is waiting.
// PARAMETERS
//   MAX_HOLD  8  grant cycles allowed while the other requester waits; 0 = no preemption
//   CNT_W     4  hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk    in   1  single clock; all state updates on rising edge
//   rst    in   1  asynchronous, active-low reset (0 = reset asserted)
//   req_x  in   1  requester X wants the mux; level, held while using it
//   req_y  in   1  requester Y wants the mux; level, held while using it
//   sel    out  1  registered mux select (0 = x input, 1 = y input)
//   gnt_x  out  1  registered grant to X; implies sel == 0
//   gnt_y  out  1  registered grant to Y; implies sel == 1
//   busy   out  1  registered; 1 whenever state != IDLE
// BEHAVIOUR
//   Reset (rst == 0, async)
//     - state = IDLE; sel, gnt_x, gnt_y, busy = 0; hold_cnt = 0.
//     - last = Y, so X wins the first tie.
//     - Mid-grant reset drops the grant immediately (async), not at the next edge.
//   States: IDLE, GNT_X, GNT_Y, SWITCH (all outputs registered from next-state)
//   IDLE
//     - Target selection: both requests -> the side != last; one request -> that side; none -> stay in IDLE.
//     - Target == current sel -> next state GNT_<target>; grant is visible 1 cycle after the req edge.
//     - Target != current sel -> SWITCH; sel flips at that edge; grant follows 1 cycle later (latency 2).
//   GNT_X (GNT_Y is symmetric)
//     - gnt_x = 1 and sel = 0 for as long as the state holds.
//     - hold_cnt clears on state entry.
//     - hold_cnt increments each cycle that req_y = 1, saturating at 2**CNT_W - 1.
//     - req_x = 0 -> last = X; go to SWITCH if req_y = 1, else IDLE. gnt_x drops at that edge.
//     - MAX_HOLD != 0 && req_y = 1 && hold_cnt == MAX_HOLD-1 -> preempt: last = X, SWITCH to Y, gnt_x drops.
//   SWITCH
//     - Exactly 1 cycle; gnt_x = gnt_y = 0; sel already equals the target.
//     - Target request still high -> GNT_<target>.
//     - Target request dropped -> other side requesting ? SWITCH back : IDLE.
//   Invariants
//     - gnt_x & gnt_y never both 1.
//     - No grant in the cycle sel changes.
//     - sel is held in IDLE (no toggling with no requests).
//   Simultaneous events
//     - Owner drops its request while the other side's preempt count expires -> treated as normal release; last = owner.
//     - Both requests rise in the same cycle from IDLE -> resolved by last.
// TESTING
//   1 Reset: rst = 0 with req_x = req_y = 1 -> all outputs 0.
//     Release rst -> gnt_x = 1 on the 1st edge, sel = 0.
//   2 Single Y from IDLE (sel = 0): req_y rises -> sel = 1 at edge 1, gnt_y = 1 at edge 2, busy = 1 throughout.
//   3 Round-robin: X releases while req_y = 1 -> gnt_x = 0, sel = 1, then gnt_y = 1.
//     Later tie from IDLE -> X wins.
//   4 Preemption, MAX_HOLD = 8: hold req_x with req_y = 1 -> gnt_x high exactly 8 cycles,
//     1 SWITCH cycle, then gnt_y = 1 with req_x still high.
//   5 MAX_HOLD = 0: req_x held 100 cycles with req_y = 1 -> gnt_x stays high; no preemption.
//   6 Async reset mid-GNT_Y: rst falls between edges -> gnt_y, sel, busy drop to 0 immediately.
//     Check mutual-exclusion and no-grant-on-sel-change assertions throughout.

Source files
------------

// File: rtl/vtg_mux_arbiter.sv
// Round-robin arbiter for the shared vtg_mux 2:1 datapath between requesters X and Y.
// Owns the registered select line and issues break-before-make one-hot grants with bounded hold.
module vtg_mux_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_x,
    input  logic       req_y,
    output logic       sel,
    output logic       gnt_x,
    output logic       gnt_y,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GNT_X  = 2'd1;
    localparam logic [1:0] S_GNT_Y  = 2'd2;
    localparam logic [1:0] S_SWITCH = 2'd3;

    localparam logic             PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]       r_state;
    logic             r_sel;
    logic             r_gnt_x;
    logic             r_gnt_y;
    logic             r_busy;
    logic             r_last;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [1:0]       w_state_nxt;
    logic             w_sel_nxt;
    logic             w_last_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             w_idle_tgt;
    logic             w_req_side;
    logic             w_req_other;

    // Outside IDLE, sel always names the side that owns (or is about to own) the mux.
    assign w_idle_tgt  = (req_x && req_y) ? ~r_last : req_y;
    assign w_req_side  = r_sel ? req_y : req_x;
    assign w_req_other = r_sel ? req_x : req_y;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_x || req_y) begin
                    if (w_idle_tgt == r_sel) begin
                        w_state_nxt = w_idle_tgt ? S_GNT_Y : S_GNT_X;
                        w_hold_nxt  = '0;
                    end else begin
                        w_state_nxt = S_SWITCH;
                        w_sel_nxt   = w_idle_tgt;
                    end
                end
            end
            S_GNT_X, S_GNT_Y: begin
                if (!w_req_side) begin
                    w_last_nxt = r_sel;
                    if (w_req_other) begin
                        w_state_nxt = S_SWITCH;
                        w_sel_nxt   = ~r_sel;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (PREEMPT_EN && w_req_other && (r_hold_cnt == HOLD_LAST)) begin
                    w_last_nxt  = r_sel;
                    w_state_nxt = S_SWITCH;
                    w_sel_nxt   = ~r_sel;
                end else if (w_req_other && (r_hold_cnt != CNT_MAX)) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            S_SWITCH: begin
                if (w_req_side) begin
                    w_state_nxt = r_sel ? S_GNT_Y : S_GNT_X;
                    w_hold_nxt  = '0;
                end else if (w_req_other) begin
                    w_sel_nxt = ~r_sel;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b0;
            r_gnt_x    <= 1'b0;
            r_gnt_y    <= 1'b0;
            r_busy     <= 1'b0;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_gnt_x    <= (w_state_nxt == S_GNT_X);
            r_gnt_y    <= (w_state_nxt == S_GNT_Y);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign sel       = r_sel;
    assign gnt_x     = r_gnt_x;
    assign gnt_y     = r_gnt_y;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_vtg_mux_arbiter.sv
// Bench for vtg_mux_arbiter: a preempting instance and a no-preempt instance share stimulus
// and are scored against an owner/gap reference model through per-instance expected queues.
module tb_vtg_mux_arbiter;

  logic       clk;
  logic       rst;
  logic       req_x;
  logic       req_y;
  logic       sel0, gnt_x0, gnt_y0, busy0;
  logic       sel1, gnt_x1, gnt_y1, busy1;
  logic [1:0] dbg0, dbg1;

  int n_checks;
  int n_pass;

  // expected {busy, gnt_y, gnt_x, sel}
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];

  // reference model: owner -1/0(X)/1(Y), gap = one-cycle handover pending toward sel
  int m_owner[2];
  int m_gap[2];
  int m_sel[2];
  int m_last[2];
  int m_held[2];
  int m_max_hold[2];

  logic prev_sel0, prev_sel1;

  vtg_mux_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .req_x(req_x), .req_y(req_y),
    .sel(sel0), .gnt_x(gnt_x0), .gnt_y(gnt_y0), .busy(busy0), .dbg_state(dbg0)
  );

  vtg_mux_arbiter #(.MAX_HOLD(0), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .req_x(req_x), .req_y(req_y),
    .sel(sel1), .gnt_x(gnt_x1), .gnt_y(gnt_y1), .busy(busy1), .dbg_state(dbg1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input int k);
    int rq[2];
    int o;
    int t;
    logic [3:0] e;
    rq[0] = int'(req_x);
    rq[1] = int'(req_y);
    if (rst !== 1'b1) begin
      m_owner[k] = -1; m_gap[k] = 0; m_sel[k] = 0; m_last[k] = 1; m_held[k] = 0;
    end else if (m_gap[k] != 0) begin
      if (rq[m_sel[k]] != 0) begin
        m_owner[k] = m_sel[k]; m_gap[k] = 0; m_held[k] = 0;
      end else if (rq[1 - m_sel[k]] != 0) begin
        m_sel[k] = 1 - m_sel[k];
      end else begin
        m_gap[k] = 0;
      end
    end else if (m_owner[k] >= 0) begin
      o = m_owner[k];
      if (rq[o] == 0) begin
        m_last[k] = o; m_owner[k] = -1;
        if (rq[1 - o] != 0) begin m_gap[k] = 1; m_sel[k] = 1 - o; end
      end else if (m_max_hold[k] != 0 && rq[1 - o] != 0 && m_held[k] == m_max_hold[k] - 1) begin
        m_last[k] = o; m_owner[k] = -1; m_gap[k] = 1; m_sel[k] = 1 - o;
      end else if (rq[1 - o] != 0 && m_held[k] < 15) begin
        m_held[k]++;
      end
    end else if (rq[0] != 0 || rq[1] != 0) begin
      if (rq[0] != 0 && rq[1] != 0) t = 1 - m_last[k];
      else t = (rq[0] != 0) ? 0 : 1;
      if (t == m_sel[k]) begin m_owner[k] = t; m_held[k] = 0; end
      else begin m_gap[k] = 1; m_sel[k] = t; end
    end
    e[0] = (m_sel[k] != 0);
    e[1] = (m_gap[k] == 0 && m_owner[k] == 0);
    e[2] = (m_gap[k] == 0 && m_owner[k] == 1);
    e[3] = (m_gap[k] != 0 || m_owner[k] >= 0);
    if (k == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // scoreboard monitor and invariant checks
  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      check("sb_dut0", {busy0, gnt_y0, gnt_x0, sel0}, e);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      check("sb_dut1", {busy1, gnt_y1, gnt_x1, sel1}, e);
    end
    check("mutex0", 4'(gnt_x0 & gnt_y0), 4'd0);
    check("mutex1", 4'(gnt_x1 & gnt_y1), 4'd0);
    check("gnt_sel0", 4'((gnt_x0 & sel0) | (gnt_y0 & ~sel0)), 4'd0);
    if (sel0 !== prev_sel0) check("bbm0", 4'({gnt_y0, gnt_x0}), 4'd0);
    if (sel1 !== prev_sel1) check("bbm1", 4'({gnt_y1, gnt_x1}), 4'd0);
    prev_sel0 = sel0;
    prev_sel1 = sel1;
  end

  initial begin
    int n;
    int hi;
    bit done;
    n_checks = 0;
    n_pass = 0;
    m_max_hold[0] = 8;
    m_max_hold[1] = 0;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_gap[k] = 0; m_sel[k] = 0; m_last[k] = 1; m_held[k] = 0;
    end
    prev_sel0 = 1'b0;
    prev_sel1 = 1'b0;

    // reset with both requests high
    rst = 1'b0;
    req_x = 1'b1;
    req_y = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out0", {busy0, gnt_y0, gnt_x0, sel0}, 4'd0);
    check("rst_out1", {busy1, gnt_y1, gnt_x1, sel1}, 4'd0);
    rst = 1'b1;

    // preemption on dut0, none on dut1
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (gnt_x0) n++;
      else if (n > 0) done = 1'b1;
    end
    check("preempt_done", 4'(done), 4'd1);
    check("preempt_len", 4'(n), 4'd8);
    check("preempt_switch", {busy0, gnt_y0, gnt_x0, sel0}, 4'b1001);
    @(negedge clk);
    check("preempt_gnt_y", 4'({gnt_y0, req_x}), 4'b0011);

    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt_x1) hi++;
    end
    check("no_preempt_hold", 4'(hi == 100), 4'd1);

    // async reset while dut0 is in GNT_Y
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (gnt_y0) done = 1'b1;
    end
    check("reach_gnt_y", 4'(done), 4'd1);
    #2;
    rst = 1'b0;
    req_x = 1'b0;
    req_y = 1'b0;
    #1;
    check("async_rst0", {busy0, gnt_y0, gnt_x0, sel0}, 4'd0);
    check("async_rst1", {busy1, gnt_y1, gnt_x1, sel1}, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    // single Y from IDLE with sel = 0
    @(negedge clk);
    req_y = 1'b1;
    @(negedge clk);
    check("y_edge1", {busy0, gnt_y0, gnt_x0, sel0}, 4'b1001);
    @(negedge clk);
    check("y_edge2", {busy0, gnt_y0, gnt_x0, sel0}, 4'b1101);

    // Y releases with X waiting
    req_x = 1'b1;
    req_y = 1'b0;
    @(negedge clk);
    check("y_rel_switch", {busy0, gnt_y0, gnt_x0, sel0}, 4'b1000);
    @(negedge clk);
    check("y_rel_gnt_x", {busy0, gnt_y0, gnt_x0, sel0}, 4'b1010);

    // X releases with Y waiting
    req_y = 1'b1;
    @(negedge clk);
    req_x = 1'b0;
    @(negedge clk);
    check("x_rel_switch", {busy0, gnt_y0, gnt_x0, sel0}, 4'b1001);
    @(negedge clk);
    check("x_rel_gnt_y", {busy0, gnt_y0, gnt_x0, sel0}, 4'b1101);

    // Y releases alone: IDLE holds sel, then a tie goes to X
    req_y = 1'b0;
    @(negedge clk);
    check("idle_hold_sel", {busy0, gnt_y0, gnt_x0, sel0}, 4'b0001);
    @(negedge clk);
    check("idle_hold_sel2", {busy0, gnt_y0, gnt_x0, sel0}, 4'b0001);
    req_x = 1'b1;
    req_y = 1'b1;
    @(negedge clk);
    check("tie_switch", {busy0, gnt_y0, gnt_x0, sel0}, 4'b1000);
    @(negedge clk);
    check("tie_gnt_x", {busy0, gnt_y0, gnt_x0, sel0}, 4'b1010);

    // randomized level requests with occasional async reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req_x = ~req_x;
      if ($urandom_range(0, 7) == 0) req_y = ~req_y;
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    req_x = 1'b0;
    req_y = 1'b0;
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
